// File: rtl/byte_striping_pkg.sv
// Shared definitions for the two-lane striper and the matching unstriping stage.
package byte_striping_pkg;

  localparam int          BS_DATA_W   = 32;
  localparam logic [31:0] BS_PAD_WORD = 32'h0000_00BC;

  // EVEN: next word goes to lane 0. ODD: lane 0 written, next word goes to lane 1.
  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } bs_state_e;

endpackage

// File: rtl/byte_striping_if.sv
// Input word stream plus the two striped output lanes.
interface byte_striping_if #(
  parameter int DATA_W = byte_striping_pkg::BS_DATA_W
);

  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic              pad_out;

  // Source side: drives words, observes lanes.
  modport master (
    output valid_in, data_in,
    input  lane_0, valid_0, lane_1, valid_1, pad_out
  );

  // Striper side.
  modport slave (
    input  valid_in, data_in,
    output lane_0, valid_0, lane_1, valid_1, pad_out
  );

endinterface

// File: rtl/byte_striping.sv
// Alternates valid input words between lane 0 and lane 1; pads lane 1 after an
// idle timeout so a half-filled pair never lingers.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int                DATA_W   = BS_DATA_W,
  parameter int                TIMEOUT  = 4,
  parameter logic [DATA_W-1:0] PAD_WORD = DATA_W'(BS_PAD_WORD)
) (
  input  logic            clk_2f,
  input  logic            reset_L,
  byte_striping_if.slave  bus
);

  // Width 1 when padding is disabled keeps the counter legal; it just saturates.
  localparam int               CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam bit               PAD_EN  = (TIMEOUT != 0);

  bs_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] lane_0_q, lane_0_d, lane_1_q, lane_1_d;
  logic              valid_0_q, valid_0_d, valid_1_q, valid_1_d;
  logic              pad_q, pad_d;

  assign bus.lane_0  = lane_0_q;
  assign bus.valid_0 = valid_0_q;
  assign bus.lane_1  = lane_1_q;
  assign bus.valid_1 = valid_1_q;
  assign bus.pad_out = pad_q;

  // Saturating idle count; only meaningful while waiting in ODD.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next state and next registered outputs; every output defaults to idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lane_0_d  = '0;
    valid_0_d = 1'b0;
    lane_1_d  = '0;
    valid_1_d = 1'b0;
    pad_d     = 1'b0;
    case (state_q)
      EVEN: begin
        cnt_d = '0;
        if (bus.valid_in) begin
          lane_0_d  = bus.data_in;
          valid_0_d = 1'b1;
          state_d   = ODD;
        end
      end
      ODD: begin
        if (bus.valid_in) begin
          // A real word wins over a timeout landing on the same edge.
          lane_1_d  = bus.data_in;
          valid_1_d = 1'b1;
          state_d   = EVEN;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
          if (PAD_EN && cnt_inc == CNT_TO) begin
            lane_1_d  = PAD_WORD;
            valid_1_d = 1'b1;
            pad_d     = 1'b1;
            state_d   = EVEN;
            cnt_d     = '0;
          end
        end
      end
      default: state_d = EVEN;
    endcase
  end

  // State, idle counter and registered lane outputs; reset drops any half pair.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= EVEN;
      cnt_q     <= '0;
      lane_0_q  <= '0;
      valid_0_q <= 1'b0;
      lane_1_q  <= '0;
      valid_1_q <= 1'b0;
      pad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lane_0_q  <= lane_0_d;
      valid_0_q <= valid_0_d;
      lane_1_q  <= lane_1_d;
      valid_1_q <= valid_1_d;
      pad_q     <= pad_d;
    end
  end

endmodule

// File: tb/tb_byte_striping.sv
// Bench for byte_striping: table of per-cycle vectors through a scoreboard,
// plus hand-written async-reset and TIMEOUT=0 sequences.
module tb_byte_striping;
  import byte_striping_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] PAD = 32'h0000_00BC;

  logic clk_2f  = 1'b0;
  logic reset_L = 1'b1;
  always #5 clk_2f = ~clk_2f;

  byte_striping_if #(.DATA_W(W)) bus_a ();
  byte_striping_if #(.DATA_W(W)) bus_b ();

  byte_striping #(.DATA_W(W), .TIMEOUT(4), .PAD_WORD(PAD)) dut_a (
    .clk_2f (clk_2f),
    .reset_L(reset_L),
    .bus    (bus_a.slave)
  );

  byte_striping #(.DATA_W(W), .TIMEOUT(0), .PAD_WORD(PAD)) dut_b (
    .clk_2f (clk_2f),
    .reset_L(reset_L),
    .bus    (bus_b.slave)
  );

  // Observed tuple {valid_0, lane_0, valid_1, lane_1, pad_out}
  typedef logic [2*W+2:0] obs_t;

  function automatic obs_t pk(logic v0, logic [W-1:0] l0, logic v1, logic [W-1:0] l1, logic p);
    return {v0, l0, v1, l1, p};
  endfunction
  function automatic obs_t e0(logic [W-1:0] d); return pk(1'b1, d, 1'b0, '0, 1'b0); endfunction
  function automatic obs_t e1(logic [W-1:0] d); return pk(1'b0, '0, 1'b1, d, 1'b0); endfunction
  function automatic obs_t epad();              return pk(1'b0, '0, 1'b1, PAD, 1'b1); endfunction
  function automatic obs_t eidle();             return '0; endfunction

  function automatic obs_t obs(bit sel);
    if (sel) return pk(bus_b.valid_0, bus_b.lane_0, bus_b.valid_1, bus_b.lane_1, bus_b.pad_out);
    return pk(bus_a.valid_0, bus_a.lane_0, bus_a.valid_1, bus_a.lane_1, bus_a.pad_out);
  endfunction

  typedef struct {
    logic         vi;
    logic [W-1:0] di;
    obs_t         exp;
  } vec_t;

  typedef struct {
    bit    sel;
    obs_t  exp;
    string nm;
    int    tag;
  } sb_t;

  vec_t tbl[21];
  sb_t  sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(string nm, int tag, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got v0/l0/v1/l1/pad=%h required=%h", nm, tag, got, exp);
    end
  endtask

  // Compare whatever the previous posedge produced.
  task automatic drain();
    sb_t s;
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      chk(s.nm, s.tag, obs(s.sel), s.exp);
    end
  endtask

  // On a negedge: check last cycle, drive this cycle, queue what the next posedge must yield.
  task automatic step(bit sel, logic vi, logic [W-1:0] di, obs_t exp, string nm, int tag);
    sb_t s;
    @(negedge clk_2f);
    drain();
    bus_a.valid_in = sel ? 1'b0 : vi;
    bus_a.data_in  = sel ? '0 : di;
    bus_b.valid_in = sel ? vi : 1'b0;
    bus_b.data_in  = sel ? di : '0;
    s.sel = sel; s.exp = exp; s.nm = nm; s.tag = tag;
    sbq.push_back(s);
  endtask

  task automatic flush();
    @(negedge clk_2f);
    drain();
    bus_a.valid_in = 1'b0; bus_a.data_in = '0;
    bus_b.valid_in = 1'b0; bus_b.data_in = '0;
  endtask

  initial begin
    // Each row: input this cycle, outputs expected right after its posedge.
    tbl[0]  = '{1'b1, 32'hA1A1_A1A1, e0(32'hA1A1_A1A1)};
    tbl[1]  = '{1'b1, 32'hB2B2_B2B2, e1(32'hB2B2_B2B2)};
    tbl[2]  = '{1'b1, 32'hC3C3_C3C3, e0(32'hC3C3_C3C3)};
    tbl[3]  = '{1'b1, 32'hD4D4_D4D4, e1(32'hD4D4_D4D4)};
    tbl[4]  = '{1'b0, 32'h0,         eidle()};
    tbl[5]  = '{1'b1, 32'h0000_00A1, e0(32'h0000_00A1)};
    tbl[6]  = '{1'b0, 32'h0,         eidle()};
    tbl[7]  = '{1'b0, 32'h0,         eidle()};
    tbl[8]  = '{1'b1, 32'h0000_00B2, e1(32'h0000_00B2)};
    tbl[9]  = '{1'b1, 32'hE5E5_E5E5, e0(32'hE5E5_E5E5)};
    tbl[10] = '{1'b0, 32'h0,         eidle()};
    tbl[11] = '{1'b0, 32'h0,         eidle()};
    tbl[12] = '{1'b0, 32'h0,         eidle()};
    tbl[13] = '{1'b0, 32'h0,         epad()};
    tbl[14] = '{1'b0, 32'h0,         eidle()};
    tbl[15] = '{1'b1, 32'h7777_7777, e0(32'h7777_7777)};
    tbl[16] = '{1'b0, 32'h0,         eidle()};
    tbl[17] = '{1'b0, 32'h0,         eidle()};
    tbl[18] = '{1'b0, 32'h0,         eidle()};
    tbl[19] = '{1'b1, 32'hF6F6_F6F6, e1(32'hF6F6_F6F6)};
    tbl[20] = '{1'b0, 32'h0,         eidle()};

    // Reset dominates even with valid input present.
    bus_a.valid_in = 1'b1; bus_a.data_in = 32'hDEAD_BEEF;
    bus_b.valid_in = 1'b1; bus_b.data_in = 32'hDEAD_BEEF;
    #1 reset_L = 1'b0;
    repeat (2) begin
      @(negedge clk_2f);
      chk("reset_a", 0, obs(1'b0), eidle());
      chk("reset_b", 0, obs(1'b1), eidle());
    end
    bus_a.valid_in = 1'b0; bus_a.data_in = '0;
    bus_b.valid_in = 1'b0; bus_b.data_in = '0;
    reset_L = 1'b1;

    for (int i = 0; i < 21; i++) step(1'b0, tbl[i].vi, tbl[i].di, tbl[i].exp, "vec", i);
    flush();

    // Async reset while in ODD: half pair dropped, no pad later.
    bus_a.valid_in = 1'b1; bus_a.data_in = 32'h8888_8888;
    @(posedge clk_2f);
    #1;
    bus_a.valid_in = 1'b0; bus_a.data_in = '0;
    chk("pre_rst_v0", 0, obs(1'b0), e0(32'h8888_8888));
    reset_L = 1'b0;
    #1;
    chk("async_rst", 0, obs(1'b0), eidle());
    @(negedge clk_2f);
    chk("rst_hold", 0, obs(1'b0), eidle());
    reset_L = 1'b1;
    step(1'b0, 1'b1, 32'h6767_6767, e0(32'h6767_6767), "post_rst_g7", 0);
    step(1'b0, 1'b1, 32'h1234_5678, e1(32'h1234_5678), "post_rst_pair", 0);
    flush();

    // TIMEOUT=0: lane 1 waits forever, then takes the next word.
    step(1'b1, 1'b1, 32'h9999_9999, e0(32'h9999_9999), "to0_first", 0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, '0, eidle(), "to0_idle", i);
    step(1'b1, 1'b1, 32'hAAAA_AAAA, e1(32'hAAAA_AAAA), "to0_lane1", 0);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
